// File: rtl/layer_stream_pkg.sv
// Shared definitions for the layer output streamer.
// No logic; compile-time helpers and the FILL/DRAIN state encoding.
// Not applicable (package only).
//
// Contents: clog2 constant function, activation width derivation,
// minimum-one width helper, stream_state_t encoding.
package layer_stream_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Activation width produced by a neuron with fan-in n.
    function automatic int act_length(input int n);
        return 16 + clog2(n);
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int width_min1(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } stream_state_t;

endpackage

// File: rtl/layer_output_streamer_requant8.sv
// Requantizer: right shift by SHIFT, then narrow to 8 bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its input every cycle.
//
// Ports: din (LENGTH-bit unsigned activation), dout (8-bit element),
// clamp (only with LAYER_STREAMER_SAT_EN: shifted value exceeded 255).
// Build option LAYER_STREAMER_SAT_EN selects saturation instead of truncation.
module requant8
    import layer_stream_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int SHIFT  = 8
) (
    input  logic [LENGTH-1:0] din,
    output logic [7:0]        dout
`ifdef LAYER_STREAMER_SAT_EN
    ,
    output logic              clamp
`endif
);

`ifdef LAYER_STREAMER_SAT_EN
    logic [LENGTH-1:0] q;

    assign q     = din >> SHIFT;
    // Anything above bit 7 set means the value does not fit in 8 bits.
    assign clamp = |q[LENGTH-1:8];
    assign dout  = clamp ? 8'hFF : q[7:0];
`else
    // Plain truncation: keep the low byte of the shifted value.
    assign dout = 8'(din >> SHIFT);
`endif

endmodule

// File: rtl/layer_output_streamer.sv
// Buffers one frame of M requantized activations, then streams it REPEAT times.
// Latency: first element valid the cycle after the M-th accept; 1 element/cycle.
// Backpressure: out_ready low holds out_data/out_last; act_ready low while draining.
//
// Ports: clk, rst (sync active-high); act_valid/act_in/act_ready (activation
// input); out_valid/out_data/out_ready/out_last (8-bit element stream);
// frame_done (pulse after final transfer of final pass); sat_seen (only with
// LAYER_STREAMER_SAT_EN: sticky clamp flag, cleared on rst or FILL entry).
module layer_output_streamer
    import layer_stream_pkg::*;
#(
    parameter  int N      = 1,
    parameter  int M      = 4,
    parameter  int SHIFT  = 8,
    parameter  int REPEAT = 1,
    localparam int LENGTH = act_length(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_valid,
    input  logic [LENGTH-1:0] act_in,
    output logic              act_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done
`ifdef LAYER_STREAMER_SAT_EN
    ,
    output logic              sat_seen
`endif
);

    localparam int PTR_W  = width_min1(M);
    localparam int PASS_W = width_min1(REPEAT);

    stream_state_t     state_q;
    stream_state_t     state_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PASS_W-1:0] pass_q;
    logic [7:0]        frame_buf [M];
    logic [7:0]        q8;

    logic accept;
    logic xfer;
    logic wr_last;
    logic rd_last;
    logic pass_last;
    logic frame_end;

    // Reset forces the idle-facing view immediately: ready to fill, nothing valid.
    assign act_ready = rst | (state_q == FILL);
    assign out_valid = ~rst & (state_q == DRAIN);
    assign out_data  = out_valid ? frame_buf[rd_ptr] : 8'h00;
    assign out_last  = out_valid & rd_last;

    assign accept    = act_valid & act_ready;
    assign xfer      = out_valid & out_ready;
    assign wr_last   = (wr_ptr == PTR_W'(M - 1));
    assign rd_last   = (rd_ptr == PTR_W'(M - 1));
    assign pass_last = (pass_q == PASS_W'(REPEAT - 1));
    assign frame_end = xfer & rd_last & pass_last;

`ifdef LAYER_STREAMER_SAT_EN
    logic clamp;

    requant8 #(
        .LENGTH (LENGTH),
        .SHIFT  (SHIFT)
    ) u_requant (
        .din   (act_in),
        .dout  (q8),
        .clamp (clamp)
    );

    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            sat_seen <= 1'b0;
        end else if (accept && clamp) begin
            sat_seen <= 1'b1;
        end
    end
`else
    requant8 #(
        .LENGTH (LENGTH),
        .SHIFT  (SHIFT)
    ) u_requant (
        .din  (act_in),
        .dout (q8)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill completes on the accept at the last slot, drain
    // completes on the last transfer of the last pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && wr_last) state_d = DRAIN;
            DRAIN:   if (frame_end)         state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Pointers, pass counter and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pass_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (accept) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                if (rd_last) begin
                    rd_ptr <= '0;
                    pass_q <= pass_last ? '0 : pass_q + PASS_W'(1);
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Frame storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            frame_buf[wr_ptr] <= q8;
        end
    end

endmodule

// File: tb/tb_layer_output_streamer.sv
// Self-checking bench for layer_output_streamer.
// Three instances share stimulus; `sel` picks which one is checked.
// Scoreboard queue holds expected {data,last} pushed when a frame is driven.
module tb_layer_output_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        act_valid;
    logic [19:0] act_in;
    logic        out_ready;

    logic        rdy [3];
    logic        vld [3];
    logic [7:0]  dat [3];
    logic        lst [3];
    logic        fd  [3];
`ifdef LAYER_STREAMER_SAT_EN
    logic        sat_v [3];
`endif

    always #5 clk = ~clk;

    // dut 0: basic configuration
    layer_output_streamer #(.N(1), .M(4), .SHIFT(8), .REPEAT(1)) dut_a (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_in(act_in[15:0]),
        .act_ready(rdy[0]), .out_valid(vld[0]), .out_data(dat[0]),
        .out_ready(out_ready), .out_last(lst[0]), .frame_done(fd[0])
`ifdef LAYER_STREAMER_SAT_EN
        , .sat_seen(sat_v[0])
`endif
    );

    // dut 1: three passes per frame
    layer_output_streamer #(.N(1), .M(4), .SHIFT(8), .REPEAT(3)) dut_b (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_in(act_in[15:0]),
        .act_ready(rdy[1]), .out_valid(vld[1]), .out_data(dat[1]),
        .out_ready(out_ready), .out_last(lst[1]), .frame_done(fd[1])
`ifdef LAYER_STREAMER_SAT_EN
        , .sat_seen(sat_v[1])
`endif
    );

    // dut 2: wide activations (N=16 -> 20 bits), single-element frames
    layer_output_streamer #(.N(16), .M(1), .SHIFT(8), .REPEAT(1)) dut_c (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_in(act_in),
        .act_ready(rdy[2]), .out_valid(vld[2]), .out_data(dat[2]),
        .out_ready(out_ready), .out_last(lst[2]), .frame_done(fd[2])
`ifdef LAYER_STREAMER_SAT_EN
        , .sat_seen(sat_v[2])
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    typedef struct {
        logic [19:0] act;
        logic [7:0]  exp_d;
        logic        exp_sat;
    } vec_t;

    int     checks   = 0;
    int     errors   = 0;
    int     sel      = 0;
    bit     mon_en   = 1'b0;
    int     fd_count = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference requantizer with SHIFT=8.
    function automatic logic [7:0] model_q8(input logic [19:0] v);
        logic [19:0] q;
        q = v >> 8;
`ifdef LAYER_STREAMER_SAT_EN
        return (q > 20'd255) ? 8'hFF : q[7:0];
`else
        return q[7:0];
`endif
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fd[sel]) fd_count++;
        if (mon_en && !rst) begin
            chk("exclusive", {31'd0, vld[sel] & rdy[sel]}, 32'd0);
            if (vld[sel] && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=0x%0h required=none", dat[sel]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", {24'd0, dat[sel]}, {24'd0, mon_e.d});
                    chk("sb_last", {31'd0, lst[sel]}, {31'd0, mon_e.l});
                end
            end
        end
    end

    // Two reset cycles; checks reset-state outputs of the selected instance.
    task automatic do_reset();
        rst = 1'b1; act_valid = 1'b0; act_in = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_act_ready", {31'd0, rdy[sel]}, 32'd1);
        chk("rst_out_valid", {31'd0, vld[sel]}, 32'd0);
        chk("rst_out_data",  {24'd0, dat[sel]}, 32'd0);
        chk("rst_out_last",  {31'd0, lst[sel]}, 32'd0);
        chk("rst_frame_done", {31'd0, fd[sel]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_act_ready", {31'd0, rdy[sel]}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Drive n back-to-back accepts; caller is just after a rising edge in FILL.
    task automatic send_frame(input logic [19:0] v [4], input int n, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                exp_q.push_back('{d: model_q8(v[i]), l: (i == n - 1)});
        for (int i = 0; i < n; i++) begin
            act_valid = 1'b1;
            act_in    = v[i];
            @(posedge clk); #1;
        end
        act_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fd[sel]) seen = 1'b1;
        end
        chk({name, "_frame_done"}, {31'd0, seen}, 32'd1);
        chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] fr [4];
        vec_t        vt [7];

        // ---------------- basic frame on dut_a ----------------
        sel = 0;
        do_reset();
        mon_en = 1'b1;
        fr = '{20'h00100, 20'h00200, 20'h00300, 20'h00400};
        send_frame(fr, 4, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("basic_valid", {31'd0, vld[0]}, 32'd1);
            chk("basic_data",  {24'd0, dat[0]}, k + 1);
            chk("basic_last",  {31'd0, lst[0]}, (k == 3) ? 32'd1 : 32'd0);
            chk("basic_act_ready", {31'd0, rdy[0]}, 32'd0);
        end
        @(negedge clk);
        chk("basic_frame_done", {31'd0, fd[0]}, 32'd1);
        chk("basic_ready_back", {31'd0, rdy[0]}, 32'd1);
        chk("basic_idle_valid", {31'd0, vld[0]}, 32'd0);
        chk("basic_idle_data",  {24'd0, dat[0]}, 32'd0);
        @(negedge clk);
        chk("basic_done_pulse", {31'd0, fd[0]}, 32'd0);

        // ---------------- narrowing patterns on dut_a ----------------
        @(posedge clk); #1;
        fr = '{20'h0FFFF, 20'h000FF, 20'h08000, 20'h01234};
        send_frame(fr, 4, 1);
        wait_done("narrow", 20);

        // ---------------- backpressure on dut_a ----------------
        @(posedge clk); #1;
        fr = '{20'h00100, 20'h00200, 20'h00300, 20'h00400};
        send_frame(fr, 4, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        act_valid = 1'b1;
        act_in    = 20'h0AA00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_data",      {24'd0, dat[0]}, 32'd3);
            chk("stall_valid",     {31'd0, vld[0]}, 32'd1);
            chk("stall_last",      {31'd0, lst[0]}, 32'd0);
            chk("stall_act_ready", {31'd0, rdy[0]}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        act_valid = 1'b0;
        wait_done("stall", 20);

        // ---------------- reset mid-DRAIN on dut_a ----------------
        @(posedge clk); #1;
        mon_en = 1'b0;
        send_frame(fr, 4, 1);
        exp_q.delete();
        @(negedge clk);
        chk("mid_e0", {24'd0, dat[0]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_e1", {24'd0, dat[0]}, 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("mid_rst_valid", {31'd0, vld[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_valid", {31'd0, vld[0]}, 32'd0);
        chk("mid_after_ready", {31'd0, rdy[0]}, 32'd1);
        chk("mid_after_data",  {24'd0, dat[0]}, 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        fr = '{20'h00500, 20'h00600, 20'h00700, 20'h00800};
        send_frame(fr, 4, 1);
        @(negedge clk);
        chk("mid_new_first", {24'd0, dat[0]}, 32'd5);
        wait_done("mid_new", 20);

        // ---------------- repeat on dut_b ----------------
        mon_en = 1'b0;
        sel = 1;
        exp_q.delete();
        do_reset();
        mon_en   = 1'b1;
        fd_count = 0;
        fr = '{20'h00700, 20'h00800, 20'h00900, 20'h00A00};
        send_frame(fr, 4, 3);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rep_valid", {31'd0, vld[1]}, 32'd1);
            chk("rep_data",  {24'd0, dat[1]}, 7 + (k % 4));
            chk("rep_last",  {31'd0, lst[1]}, (k % 4 == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("rep_frame_done", {31'd0, fd[1]}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rep_done_count", fd_count, 32'd1);
        chk("rep_sb_empty", exp_q.size(), 32'd0);

        // ---------------- requant table on dut_c (M=1) ----------------
        mon_en = 1'b0;
        sel = 2;
        exp_q.delete();
        do_reset();
        mon_en = 1'b1;
`ifdef LAYER_STREAMER_SAT_EN
        vt[0] = '{20'h00100, 8'h01, 1'b0};
        vt[1] = '{20'h0FF00, 8'hFF, 1'b0};
        vt[2] = '{20'h12300, 8'hFF, 1'b1};
        vt[3] = '{20'hFFFFF, 8'hFF, 1'b1};
        vt[4] = '{20'h000FF, 8'h00, 1'b0};
        vt[5] = '{20'h08000, 8'h80, 1'b0};
        vt[6] = '{20'h10000, 8'hFF, 1'b1};
`else
        vt[0] = '{20'h00100, 8'h01, 1'b0};
        vt[1] = '{20'h0FF00, 8'hFF, 1'b0};
        vt[2] = '{20'h12300, 8'h23, 1'b0};
        vt[3] = '{20'hFFFFF, 8'hFF, 1'b0};
        vt[4] = '{20'h000FF, 8'h00, 1'b0};
        vt[5] = '{20'h08000, 8'h80, 1'b0};
        vt[6] = '{20'h10000, 8'h00, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{d: vt[i].exp_d, l: 1'b1});
            act_valid = 1'b1;
            act_in    = vt[i].act;
            @(posedge clk); #1;
            act_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", {31'd0, vld[2]}, 32'd1);
            chk("tbl_last",  {31'd0, lst[2]}, 32'd1);
`ifdef LAYER_STREAMER_SAT_EN
            chk("tbl_sat_seen", {31'd0, sat_v[2]}, {31'd0, vt[i].exp_sat});
`endif
            wait_done("tbl", 5);
`ifdef LAYER_STREAMER_SAT_EN
            chk("tbl_sat_cleared", {31'd0, sat_v[2]}, 32'd0);
`endif
            @(posedge clk); #1;
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
